edge_generator: RTL and testbench

EDGE_GENERATOR -- requirements
Module: edge_generator

---
 rtl/edge_generator_pkg.sv | 21 ++
 rtl/edge_generator.sv | 140 ++++++++++++++
 tb/tb_edge_generator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/edge_generator_pkg.sv
// Shared definitions for the edge generator.
//   edge_state_t : FSM state encoding (IDLE, ACTIVE, GAP)
//   max_int      : larger of two integers, for sizing from parameters
//   width_for    : bits needed to hold the values 0..n-1 (never less than 1)
package edge_generator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } edge_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_generator.sv
// Pulse generator with a bounded request queue.
// Each accepted request on pulse_in produces one pulse of HIGH_TICKS clk_en
// ticks at ACTIVE_LEVEL.
// Each pulse is followed by a gap of at least LOW_TICKS ticks at the
// inactive level.
// Requests that arrive while a pulse or gap is in progress are counted,
// up to PENDING_MAX of them.
//
// Ports:
//   clk       : single clock
//   reset_n   : asynchronous active-low reset
//   clk_en    : tick qualifier; nothing advances while it is low
//   pulse_in  : single-cycle request, sampled on clk_en ticks
//   level_out : registered generated waveform
//   busy      : high whenever the FSM is not IDLE
//   pending   : number of queued requests
//   overflow  : registered one-cycle pulse when a request is dropped
module edge_generator
    import edge_generator_pkg::*;
#(
    parameter bit ACTIVE_LEVEL = 1'b1,
    parameter int HIGH_TICKS   = 4,
    parameter int LOW_TICKS    = 4,
    parameter int PENDING_MAX  = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clk_en,
    input  logic                               pulse_in,
    output logic                               level_out,
    output logic                               busy,
    output logic [$clog2(PENDING_MAX+1)-1:0]   pending,
    output logic                               overflow
);

    localparam int CNT_W  = width_for(max_int(HIGH_TICKS, LOW_TICKS));
    localparam int PEND_W = $clog2(PENDING_MAX + 1);

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_TICKS - 1);
    localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PENDING_MAX);

    edge_state_t        state, state_next;
    logic [CNT_W-1:0]   count, count_next;
    logic [PEND_W-1:0]  pending_next;
    logic               level_next;
    logic               enqueue, dequeue, drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            pending   <= '0;
            level_out <= ~ACTIVE_LEVEL;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            pending   <= pending_next;
            level_out <= level_next;
            overflow  <= drop;
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count;
        pending_next = pending;
        level_next   = level_out;
        enqueue      = 1'b0;
        dequeue      = 1'b0;
        drop         = 1'b0;

        if (clk_en) begin
            unique case (state)
                IDLE: begin
                    if (pulse_in) begin
                        state_next = ACTIVE;
                        count_next = HIGH_LOAD;
                        level_next = ACTIVE_LEVEL;
                    end
                end
                ACTIVE: begin
                    enqueue = pulse_in;
                    if (count == '0) begin
                        state_next = GAP;
                        count_next = LOW_LOAD;
                        level_next = ~ACTIVE_LEVEL;
                    end else begin
                        count_next = count - 1'b1;
                    end
                end
                GAP: begin
                    if (count == '0) begin
                        if (pending != '0) begin
                            // Queued requests are served before a new one.
                            // A new one arriving now joins the queue.
                            dequeue    = 1'b1;
                            enqueue    = pulse_in;
                            state_next = ACTIVE;
                            count_next = HIGH_LOAD;
                            level_next = ACTIVE_LEVEL;
                        end else if (pulse_in) begin
                            // Empty queue: the request starts immediately.
                            // It never enters the queue.
                            state_next = ACTIVE;
                            count_next = HIGH_LOAD;
                            level_next = ACTIVE_LEVEL;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        enqueue    = pulse_in;
                        count_next = count - 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                    level_next = ~ACTIVE_LEVEL;
                end
            endcase

            // A simultaneous enqueue and dequeue leaves the count unchanged.
            // That case never overflows, because a slot frees on the same tick.
            if (enqueue && !dequeue) begin
                if (pending == PEND_FULL) begin
                    drop = 1'b1;
                end else begin
                    pending_next = pending + PEND_W'(1);
                end
            end else if (dequeue && !enqueue) begin
                pending_next = pending - PEND_W'(1);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_edge_generator.sv
// Self-checking bench for edge_generator (HIGH_TICKS=3, LOW_TICKS=2,
// PENDING_MAX=2).
// Two instances share the inputs, one at each polarity.
// A tick-position model predicts every output, and directed scenarios pin
// literal values.
module tb_edge_generator;

    localparam int HT = 3;
    localparam int LT = 2;
    localparam int PM = 2;

    logic       clk;
    logic       reset_n;
    logic       clk_en;
    logic       pulse_in;
    logic       level_hi, busy_hi, overflow_hi;
    logic       level_lo, busy_lo, overflow_lo;
    logic [1:0] pending_hi, pending_lo;

    int  checks     = 0;
    int  failures   = 0;
    int  cyc        = 0;
    bit  compare_en = 1'b0;

    // Model: m_pos is the tick position inside the current pulse+gap
    // window (-1 when idle).
    // m_out counts requests waiting to start.
    int  m_pos = -1;
    int  m_out = 0;
    bit  m_ovf = 1'b0;

    edge_generator #(
        .ACTIVE_LEVEL(1'b1), .HIGH_TICKS(HT), .LOW_TICKS(LT), .PENDING_MAX(PM)
    ) dut_hi (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .pulse_in(pulse_in),
        .level_out(level_hi), .busy(busy_hi), .pending(pending_hi),
        .overflow(overflow_hi)
    );

    edge_generator #(
        .ACTIVE_LEVEL(1'b0), .HIGH_TICKS(HT), .LOW_TICKS(LT), .PENDING_MAX(PM)
    ) dut_lo (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .pulse_in(pulse_in),
        .level_out(level_lo), .busy(busy_lo), .pending(pending_lo),
        .overflow(overflow_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d",
                     name, cyc, actual, expected);
        end
    endtask

    // Drive the inputs for the current cycle.
    // Then move to the next cycle's falling edge, where outputs are stable.
    task automatic applyStimulus(input bit p, input bit en);
        pulse_in = p;
        clk_en   = en;
        @(negedge clk);
        cyc++;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_level_hi"}, int'(level_hi), 0);
        checkOutput({tag, "_level_lo"}, int'(level_lo), 1);
        checkOutput({tag, "_busy"}, int'(busy_hi), 0);
        checkOutput({tag, "_pending"}, int'(pending_hi), 0);
        checkOutput({tag, "_overflow"}, int'(overflow_hi), 0);
    endtask

    // Reset both instances, then return at the falling edge of cycle 0.
    task automatic startScenario(input string tag);
        pulse_in = 1'b0;
        clk_en   = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 checkResetState(tag);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        cyc = 0;
    endtask

    // Advance the model on each active edge, or clear it on reset.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_pos = -1;
            m_out = 0;
            m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b0;
            if (clk_en) begin
                if (m_pos < 0) begin
                    if (pulse_in) m_pos = 0;
                end else if (m_pos == HT + LT - 1) begin
                    if (m_out > 0) begin
                        m_out = m_out - 1 + int'(pulse_in);
                        m_pos = 0;
                    end else if (pulse_in) begin
                        m_pos = 0;
                    end else begin
                        m_pos = -1;
                    end
                end else begin
                    m_pos++;
                    if (pulse_in) begin
                        if (m_out < PM) m_out++;
                        else m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    // Compare both instances against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        if (compare_en) begin
            checkOutput("model_level_hi", int'(level_hi), int'(m_pos >= 0 && m_pos < HT));
            checkOutput("model_level_lo", int'(level_lo), int'(!(m_pos >= 0 && m_pos < HT)));
            checkOutput("model_busy_hi", int'(busy_hi), int'(m_pos >= 0));
            checkOutput("model_busy_lo", int'(busy_lo), int'(m_pos >= 0));
            checkOutput("model_pending_hi", int'(pending_hi), m_out);
            checkOutput("model_pending_lo", int'(pending_lo), m_out);
            checkOutput("model_overflow_hi", int'(overflow_hi), int'(m_ovf));
            checkOutput("model_overflow_lo", int'(overflow_lo), int'(m_ovf));
        end
    end

    initial begin
        int edges;
        bit prev;

        reset_n  = 1'b1;
        clk_en   = 1'b0;
        pulse_in = 1'b0;
        #1 reset_n = 1'b0;

        // Single pulse.
        startScenario("s1_reset");
        compare_en = 1'b1;
        applyStimulus(1'b1, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            checkOutput("s1_level", int'(level_hi), int'(k <= 3));
            checkOutput("s1_busy", int'(busy_hi), int'(k <= 5));
            checkOutput("s1_pending", int'(pending_hi), 0);
            applyStimulus(1'b0, 1'b1);
        end

        // Back-to-back requests fill the queue exactly.
        startScenario("s2_reset");
        for (int k = 0; k <= 15; k++) begin
            if (k >= 1)
                checkOutput("s2_level", int'(level_hi),
                            int'((k >= 1 && k <= 3) || (k >= 6 && k <= 8) || (k >= 11 && k <= 13)));
            if (k == 3) checkOutput("s2_pending_full", int'(pending_hi), 2);
            checkOutput("s2_no_overflow", int'(overflow_hi), 0);
            applyStimulus(k <= 2, 1'b1);
        end

        // The fourth request is dropped.
        startScenario("s3_reset");
        edges = 0;
        prev  = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            if (k >= 1) checkOutput("s3_overflow", int'(overflow_hi), int'(k == 4));
            if (level_hi && !prev) edges++;
            prev = level_hi;
            applyStimulus(k <= 3, 1'b1);
        end
        checkOutput("s3_pulse_count", edges, 3);

        // Ticks on even cycles only; pulses on odd cycles must be ignored.
        startScenario("s4_reset");
        for (int k = 0; k <= 14; k++) begin
            if (k >= 1) begin
                checkOutput("s4_level", int'(level_hi), int'(k <= 6));
                checkOutput("s4_busy", int'(busy_hi), int'(k <= 10));
                checkOutput("s4_pending", int'(pending_hi), 0);
            end
            applyStimulus((k == 0) || (k % 2 == 1), k % 2 == 0);
        end

        // Reset mid-pulse with one request queued.
        startScenario("s5_reset");
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("s5_pending_before", int'(pending_hi), 1);
        checkOutput("s5_level_before", int'(level_hi), 1);
        #2 reset_n = 1'b0;
        #1 checkResetState("s5_async");
        @(negedge clk);
        #2 reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("s5_level_after", int'(level_hi), 0);
            checkOutput("s5_busy_after", int'(busy_hi), 0);
        end

        // Inverted polarity, with a request on the final gap tick.
        startScenario("s6_reset");
        for (int k = 0; k <= 10; k++) begin
            if (k >= 1) begin
                checkOutput("s6_level_lo", int'(level_lo),
                            int'(!((k >= 1 && k <= 3) || (k >= 6 && k <= 8))));
                checkOutput("s6_pending", int'(pending_lo), 0);
            end
            applyStimulus((k == 0) || (k == 5), 1'b1);
        end

        // Random traffic with occasional resets, checked by the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 reset_n = 1'b0;
                #1 checkResetState("rand_reset");
                @(negedge clk);
                #2 reset_n = 1'b1;
            end
            applyStimulus($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 75);
        end

        compare_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
